// File: rtl/led_display_ctrl.sv
// Scan controller for an 8-digit 7-segment display shared by several
// 32-bit sources, with debounced button and timed auto-rotation.
module led_display_ctrl #(
    parameter int NUM_SRC         = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_FRAMES     = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [32*NUM_SRC-1:0]      i_src_data,
    input  logic [NUM_SRC-1:0]         i_src_valid,
    input  logic                       i_btn_next,
    input  logic                       i_auto_cycle,
    input  logic                       i_blank_lz,
    output logic [6:0]                 o_seg,
    output logic [7:0]                 o_an,
    output logic [$clog2(NUM_SRC)-1:0] o_src_sel,
    output logic                       o_frame_start
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(AUTO_FRAMES + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_FRAMES);

    function automatic logic [6:0] f_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h0C;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h72;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    // Round-robin search for the next valid source above cur; cur if none.
    function automatic logic [SW-1:0] f_next(input logic [SW-1:0] cur,
                                             input logic [NUM_SRC-1:0] v);
        logic [SW-1:0] r;
        logic [SW-1:0] j;
        logic          hit;
        r   = cur;
        hit = 1'b0;
        for (int k = 1; k < NUM_SRC; k++) begin
            j = SW'((int'(cur) + k) % NUM_SRC);
            if (!hit && v[j]) begin
                r   = j;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [31:0]   r_word;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_shown;
    logic          r_fs;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_b1;
    logic          r_b2;
    logic          r_db;
    logic [DW-1:0] r_dcnt;
    logic [AW-1:0] r_acnt;

    logic [31:0]   w_src [NUM_SRC];
    logic          w_tick;
    logic          w_latch;
    logic          w_cur_ok;
    logic [SW-1:0] w_adv;
    logic [SW-1:0] w_lat_sel;
    logic [SW-1:0] w_sel_nx;
    logic [SW-1:0] w_shown_nx;
    logic [2:0]    w_idx_nx;
    logic [31:0]   w_word_nx;
    logic [31:0]   w_digit;
    logic          w_blank;
    logic [6:0]    w_seg_nx;
    logic          w_btn_req;
    logic          w_auto_req;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            w_src[k] = i_src_data[32*k +: 32];
        end
    end

    assign w_btn_req  = r_b2 && !r_db && (r_dcnt == DB_MAX);
    assign w_auto_req = i_auto_cycle && (r_acnt == AUTO_MAX);

    always_comb begin
        w_tick     = (r_pre == PRE_MAX);
        w_latch    = w_tick && (r_idx == 3'd7);
        w_adv      = f_next(r_sel, i_src_valid);
        w_cur_ok   = i_src_valid[r_sel];
        w_lat_sel  = w_cur_ok ? r_sel : w_adv;
        w_idx_nx   = w_tick ? r_idx + 3'd1 : r_idx;
        w_word_nx  = r_word;
        w_shown_nx = r_shown;
        if (w_latch) begin
            w_word_nx  = (|i_src_valid) ? w_src[w_lat_sel] : 32'h0;
            w_shown_nx = w_lat_sel;
        end
        // Button and auto share one advance; an invalid source at latch also advances.
        w_sel_nx = (w_btn_req || w_auto_req || (w_latch && !w_cur_ok)) ? w_adv : r_sel;
        w_digit  = w_word_nx >> {w_idx_nx, 2'b00};
        w_blank  = i_blank_lz && (w_idx_nx != 3'd0) && (w_digit == 32'h0);
        w_seg_nx = w_blank ? 7'h7F : f_font(w_digit[3:0]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_sel   <= '0;
            r_shown <= '0;
            r_fs    <= 1'b0;
            r_an    <= 8'hFE;
            r_seg   <= 7'h01;
            r_b1    <= 1'b0;
            r_b2    <= 1'b0;
            r_db    <= 1'b0;
            r_dcnt  <= '0;
            r_acnt  <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_idx   <= w_idx_nx;
            r_word  <= w_word_nx;
            r_sel   <= w_sel_nx;
            r_shown <= w_shown_nx;
            r_fs    <= w_latch;
            r_an    <= ~(8'b1 << w_idx_nx);
            r_seg   <= w_seg_nx;
            r_b1    <= i_btn_next;
            r_b2    <= r_b1;
            if (r_b2 == r_db) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_MAX) begin
                r_db   <= r_b2;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (!i_auto_cycle || w_auto_req) begin
                r_acnt <= '0;
            end else if (w_latch) begin
                r_acnt <= r_acnt + 1'b1;
            end
        end
    end

    assign o_an          = r_an;
    assign o_seg         = r_seg;
    assign o_src_sel     = r_shown;
    assign o_frame_start = r_fs;

endmodule
